// File: rtl/uart_rx_if.sv
// Byte-output handshake bundle for the UART receiver: data/valid/ready plus error pulses.
interface uart_rx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: RX synchroniser, rational 16x oversampling tick,
// mid-bit sampling FSM and a valid/ready holding register with error pulses.
module uart_rx #(
  parameter int unsigned CLOCK_MHZ = 16,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_rx,
  uart_rx_if.master    bus
);

  localparam int unsigned STEP    = BAUD_RATE * 16;
  localparam int unsigned LIMIT   = CLOCK_MHZ * 1_000_000;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned SCNT_W  = 4;
  localparam int unsigned BIDX_W  = 3;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic                rxs;
  logic                tick;
  logic                byte_done;
  logic [ACC_W:0]      acc_sum;

  assign rxs = sync_q[1];

  // Rational accumulator: one tick whenever the running sum crosses LIMIT.
  always_comb begin
    acc_sum = {1'b0, acc_q} + (ACC_W+1)'(STEP);
    if (acc_sum >= (ACC_W+1)'(LIMIT)) begin
      acc_d = ACC_W'(acc_sum - (ACC_W+1)'(LIMIT));
`ifdef TESTING
      tick  = 1'b1;
`else
      tick  = 1'b1;
`endif
    end else begin
      acc_d = ACC_W'(acc_sum);
`ifdef TESTING
      tick  = 1'b1;
`else
      tick  = 1'b0;
`endif
    end
  end

  // Frame FSM plus holding register next-state logic.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], i_rx};
    scnt_d      = scnt_q;
    bidx_d      = bidx_q;
    sh_d        = sh_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            scnt_d  = '0;
          end
        end
        START: begin
          if (scnt_q == SCNT_W'(7)) begin
            if (!rxs) begin
              state_d = DATA;
              scnt_d  = '0;
              bidx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        DATA: begin
          if (scnt_q == SCNT_W'(15)) begin
            sh_d   = {rxs, sh_q[DATA_W-1:1]};
            scnt_d = '0;
            if (bidx_q == BIDX_W'(7)) begin
              state_d = STOP;
            end else begin
              bidx_d = bidx_q + BIDX_W'(1);
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        STOP: begin
          if (scnt_q == SCNT_W'(15)) begin
            scnt_d = '0;
            if (rxs) begin
              byte_done = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // A completed byte may replace one being accepted this same cycle.
    if (byte_done) begin
      if (!valid_q || bus.i_ready) begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      acc_q       <= '0;
      scnt_q      <= '0;
      bidx_q      <= '0;
      sh_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      acc_q       <= acc_d;
      scnt_q      <= scnt_d;
      bidx_q      <= bidx_d;
      sh_q        <= sh_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at default 16 MHz / 115200 baud.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT = 139;  // ~16e6/115200 clocks per bit

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  int fe_cnt = 0, ov_cnt = 0, fe_wide = 0, ov_wide = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0;
  int fe_base, ov_base;

  uart_rx_if bus ();

  uart_rx #(.CLOCK_MHZ(16), .BAUD_RATE(115200)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_rx    (rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Pulse counter: values read at posedge are those of the cycle just ending.
  always @(posedge clk) begin
    if (bus.o_frame_err) fe_cnt++;
    if (bus.o_overrun) ov_cnt++;
    if (bus.o_frame_err && fe_prev) fe_wide++;
    if (bus.o_overrun && ov_prev) ov_wide++;
    fe_prev = bus.o_frame_err;
    ov_prev = bus.o_overrun;
  end

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
    drive_bit(1'b1, BIT);
  endtask

  task automatic accept_one();
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    n_checks++;
    if (bus.o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.o_data); end
    n_checks++;
    if ({bus.o_frame_err, bus.o_overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {bus.o_frame_err, bus.o_overrun}); end
  endtask

  // 10000 cycles from acc=0 -> floor(10000*1843200/16e6) = 1152 ticks exactly.
  task automatic test_tick_rate();
    int ticks;
    ticks = 0;
    rx = 1'b1;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      if (dut.tick) ticks++;
      @(negedge clk);
    end
    n_checks++;
    if (ticks !== 1152) begin n_fail++; $display("FAIL tick_rate: got %0d want 1152", ticks); end
  endtask

  task automatic test_single_byte();
    fe_base = fe_cnt; ov_base = ov_cnt;
    send_frame(8'h55);
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.o_valid); end
    n_checks++;
    if (bus.o_data !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h want 55", bus.o_data); end
    repeat (40) @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL single_hold: got %b want 1", bus.o_valid); end
    accept_one();
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_accept: got %b want 0", bus.o_valid); end
    n_checks++;
    if (bus.o_data !== 8'h55) begin n_fail++; $display("FAIL single_data_kept: got %h want 55", bus.o_data); end
    n_checks++;
    if ((fe_cnt - fe_base) + (ov_cnt - ov_base) !== 0) begin n_fail++; $display("FAIL single_no_pulse: got %0d want 0", (fe_cnt - fe_base) + (ov_cnt - ov_base)); end
  endtask

  task automatic test_glitch();
    fe_base = fe_cnt;
    drive_bit(1'b0, 26);
    drive_bit(1'b1, 2 * BIT);
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", bus.o_valid); end
    n_checks++;
    if (fe_cnt - fe_base !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - fe_base); end
    send_frame(8'h3C);
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_byte: got valid=%b data=%h want 1/3c", bus.o_valid, bus.o_data); end
    accept_one();
  endtask

  task automatic test_frame_error();
    logic [7:0] b;
    b = 8'hA3;
    fe_base = fe_cnt; ov_base = ov_cnt;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
    drive_bit(1'b0, 2 * BIT);
    drive_bit(1'b1, 2 * BIT);
    n_checks++;
    if (fe_cnt - fe_base !== 1) begin n_fail++; $display("FAIL frame_err_count: got %0d want 1", fe_cnt - fe_base); end
    n_checks++;
    if (fe_wide !== 0) begin n_fail++; $display("FAIL frame_err_width: got %0d wide cycles want 0", fe_wide); end
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL frame_err_valid: got %b want 0", bus.o_valid); end
    n_checks++;
    if (ov_cnt - ov_base !== 0) begin n_fail++; $display("FAIL frame_err_no_overrun: got %0d want 0", ov_cnt - ov_base); end
    send_frame(8'h0F);
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h0F) begin n_fail++; $display("FAIL frame_err_recover: got valid=%b data=%h want 1/0f", bus.o_valid, bus.o_data); end
    accept_one();
  endtask

  task automatic test_back_to_back_overrun();
    fe_base = fe_cnt; ov_base = ov_cnt;
    send_frame(8'h01);
    send_frame(8'h02);
    n_checks++;
    if (bus.o_data !== 8'h01) begin n_fail++; $display("FAIL overrun_data: got %h want 01", bus.o_data); end
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b want 1", bus.o_valid); end
    n_checks++;
    if (ov_cnt - ov_base !== 1) begin n_fail++; $display("FAIL overrun_count: got %0d want 1", ov_cnt - ov_base); end
    n_checks++;
    if (ov_wide !== 0) begin n_fail++; $display("FAIL overrun_width: got %0d wide cycles want 0", ov_wide); end
    n_checks++;
    if (fe_cnt - fe_base !== 0) begin n_fail++; $display("FAIL overrun_no_frame_err: got %0d want 0", fe_cnt - fe_base); end
    accept_one();
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 8'h01) begin n_fail++; $display("FAIL overrun_accept: got valid=%b data=%h want 0/01", bus.o_valid, bus.o_data); end
  endtask

  task automatic test_reset_mid_frame();
    fe_base = fe_cnt; ov_base = ov_cnt;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 8'h00) begin n_fail++; $display("FAIL midreset_outputs: got valid=%b data=%h want 0/00", bus.o_valid, bus.o_data); end
    drive_bit(1'b1, 5 * BIT);
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_byte: got %b want 0", bus.o_valid); end
    n_checks++;
    if ((fe_cnt - fe_base) + (ov_cnt - ov_base) !== 0) begin n_fail++; $display("FAIL midreset_no_pulse: got %0d want 0", (fe_cnt - fe_base) + (ov_cnt - ov_base)); end
    send_frame(8'hC3);
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'hC3) begin n_fail++; $display("FAIL midreset_next_byte: got valid=%b data=%h want 1/c3", bus.o_valid, bus.o_data); end
  endtask

  initial begin
    bus.i_ready = 1'b0;
    test_reset();
    test_tick_rate();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_back_to_back_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames: the receive counterpart to the transmit path and its baud divider. It synchronises the asynchronous RX pin and generates its own 16x-oversampling tick from the system clock with an exact rational accumulator. It detects the start bit, samples data and stop bits at mid-bit, and presents each byte through a valid/ready holding register. Frame errors and overruns are flagged.

## Interface
- CLOCK_MHZ, 16, system clock frequency in MHz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- i_clk  input  1  system clock; all logic on posedge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_rx  input  1  asynchronous serial line; idle high.
- o_data  output  8  received byte; stable while o_valid=1.
- o_valid  output  1  byte available; held until accepted.
- i_ready  input  1  consumer accepts the byte when o_valid && i_ready on a clock edge.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.

## Operation
- Synchroniser: two flops on i_rx, both reset to 1. `rxs` is the second-flop output. All decisions use `rxs`.
- Tick generator: 32-bit accumulator `acc`, reset to 0. Each cycle, with `STEP = BAUD_RATE*16` and `LIMIT = CLOCK_MHZ*1_000_000`:
  - if `acc + STEP >= LIMIT`, then `acc <= acc + STEP - LIMIT` and `tick = 1`;
  - otherwise `acc <= acc + STEP` and `tick = 1'b0`.
  - Average tick rate is exactly 16 x BAUD_RATE.
  - With `TESTING` defined, `tick = 1` every cycle.
- A 4-bit sample counter `scnt`, 3-bit bit index `bidx` and 8-bit shift register `sh` advance only on cycles where tick=1.
- FSM states:
  - IDLE: on a tick with rxs=0, go to START with scnt=0.
  - START: count ticks. When scnt reaches 7 (mid start bit), sample rxs.
    - rxs=0: go to DATA, scnt=0, bidx=0.
    - rxs=1: false start, go to IDLE; no flags raised.
  - DATA: on each tick with scnt=15 (mid-bit), shift rxs into sh MSB (LSB-first line order) and wrap scnt to 0.
    - If bidx=7, go to STOP; otherwise bidx+1.
  - STOP: on the tick with scnt=15, sample rxs.
    - rxs=1: byte complete; go to IDLE.
    - rxs=0: pulse o_frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with rxs=1, then go to IDLE. This covers break conditions and prevents a false re-trigger.
- Holding register, on the cycle a byte completes:
  - o_valid=0, or o_valid && i_ready that same cycle: o_data<=sh, o_valid<=1.
  - o_valid=1 and i_ready=0: keep the old o_data, pulse o_overrun, drop the new byte.
- With no completion, o_valid && i_ready clears o_valid. o_data keeps its last value.
- Frame error and overrun cannot coincide, because a frame error discards the byte.

## Timing
- Reset (i_rst_n=0 at a clock edge) sets:
  - FSM to IDLE; scnt, bidx, sh, acc to 0;
  - synchroniser flops to 1;
  - o_data=8'h00, o_valid=0, o_frame_err=0, o_overrun=0.
- Reset mid-frame aborts the frame with no flags. The next falling edge after release starts a fresh frame.
- Input to `rxs` latency: 2 cycles.
- Start-detect uncertainty: up to 1 tick period.
- o_valid, o_frame_err and o_overrun rise one clock after the STOP-sample tick edge. The STOP-sample tick is about 9.5 bit periods after the line's falling edge.
- Pulses are exactly one i_clk cycle wide.
- The receiver is ready for a new start bit in the IDLE state immediately after a good stop sample, so it accepts back-to-back frames with a single stop bit.

## Test plan
- Tick rate: hold i_rx=1 for 16,000,000 cycles with defaults → exactly 1,843,200 tick=1 cycles.
- Single byte: send 0x55 at 115200 baud with i_ready=0 → o_valid=1, o_data=8'h55, held until i_ready=1 for one cycle, then o_valid=0 next cycle.
- Glitch: drive i_rx low for 3 tick periods, then high → no o_valid, no o_frame_err; FSM returns to IDLE; a following byte 0x3C is received correctly.
- Frame error: send 0xA3 with the stop bit forced low for 2 bit times → one-cycle o_frame_err, o_valid stays 0. After the line returns high, byte 0x0F is received as 8'h0F.
- Overrun: send 0x01 then 0x02 back-to-back with i_ready=0 → o_data=8'h01, one o_overrun pulse at the second stop bit. Then i_ready=1 → o_valid drops, o_data still 8'h01.
- Reset mid-frame: assert i_rst_n=0 for 1 cycle after the 4th data bit of 0xFF → all outputs at reset values, no pulses. Next frame 0xC3 gives o_data=8'hC3, o_valid=1.
